// File: rtl/line_event_arbiter.sv
// Captures rising edges on 8 lines, timestamps them and hands them out one at a time (round-robin).
// Latency: edge seen -> pending next clk -> ev_valid the clk after; backpressure: ev_valid holds until ack.
module line_event_arbiter #(
    parameter int TS_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      in_bus,
    input  logic [7:0]      mask,
    input  logic            ack,
    input  logic            clr_ovr,
    output logic            ev_valid,
    output logic [2:0]      ev_id,
    output logic [TS_W-1:0] ev_time,
    output logic [7:0]      pending,
    output logic [7:0]      ovr,
    output logic [TS_W-1:0] ts_now
);

    typedef enum logic {IDLE, VALID} state_t;

    state_t          state, state_nxt;
    logic [7:0]      prev;
    logic            armed;
    logic [2:0]      last_grant;
    logic [TS_W-1:0] ts_cap [8];

    logic [7:0]      rise, ack_hit, ovr_set, cap_en;
    logic [2:0]      sel, rr_idx;
    logic            sel_vld, load_ev, done;

    assign rise    = {8{armed}} & in_bus & ~prev & ~mask;
    assign ack_hit = (state == VALID && ack) ? (8'h01 << ev_id) : 8'h00;
    // A rise on a line that is still pending (and not being retired) is lost; the first edge keeps its stamp.
    assign ovr_set = rise & pending & ~ack_hit;
    assign cap_en  = rise & ~ovr_set;

    // Round-robin search starting just after the last granted line; descending loop leaves the nearest hit.
    always_comb begin
        sel     = 3'd0;
        sel_vld = 1'b0;
        rr_idx  = 3'd0;
        for (int k = 8; k >= 1; k--) begin
            rr_idx = last_grant + 3'(k);
            if (pending[rr_idx]) begin
                sel     = rr_idx;
                sel_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load_ev   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (sel_vld) begin
                    load_ev   = 1'b1;
                    state_nxt = VALID;
                end
            end
            VALID: begin
                if (ack) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ts_now     <= '0;
            prev       <= '0;
            armed      <= 1'b0;
            pending    <= '0;
            ovr        <= '0;
            last_grant <= 3'd7;
            ev_valid   <= 1'b0;
            ev_id      <= '0;
            ev_time    <= '0;
            for (int i = 0; i < 8; i++) ts_cap[i] <= '0;
        end else begin
            state   <= state_nxt;
            ts_now  <= ts_now + 1'b1;
            prev    <= in_bus;
            armed   <= 1'b1;
            pending <= (pending & ~ack_hit) | rise;
            ovr     <= (clr_ovr ? 8'h00 : ovr) | ovr_set;
            for (int i = 0; i < 8; i++) begin
                if (cap_en[i]) ts_cap[i] <= ts_now;
            end
            if (load_ev) begin
                ev_valid <= 1'b1;
                ev_id    <= sel;
                ev_time  <= ts_cap[sel];
            end else if (done) begin
                ev_valid   <= 1'b0;
                last_grant <= ev_id;
            end
        end
    end

endmodule

// File: tb/tb_line_event_arbiter.sv
// Directed bench for line_event_arbiter with an event-level reference model checked every cycle.
module tb_line_event_arbiter;

    localparam int TS_W = 4;
    localparam int TS_M = 1 << TS_W;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [7:0]      in_bus = 8'hFF;
    logic [7:0]      mask = 8'h00;
    logic            ack = 1'b0;
    logic            clr_ovr = 1'b0;
    logic            ev_valid;
    logic [2:0]      ev_id;
    logic [TS_W-1:0] ev_time;
    logic [7:0]      pending;
    logic [7:0]      ovr;
    logic [TS_W-1:0] ts_now;

    int checks = 0;
    int errors = 0;

    line_event_arbiter #(.TS_W(TS_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .mask(mask), .ack(ack),
        .clr_ovr(clr_ovr), .ev_valid(ev_valid), .ev_id(ev_id), .ev_time(ev_time),
        .pending(pending), .ovr(ovr), .ts_now(ts_now)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: per-line event slots plus a single "presented" event.
    int       m_ts, m_id, m_time, m_last;
    int       m_cap [8];
    bit [7:0] m_prev, m_pend, m_old, m_ovr, m_rise, m_set;
    bit       m_armed, m_busy, m_take, m_found;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ts = 0; m_prev = 0; m_armed = 0; m_pend = 0; m_ovr = 0;
            m_busy = 0; m_id = 0; m_time = 0; m_last = 7;
            for (int i = 0; i < 8; i++) m_cap[i] = 0;
        end else begin
            m_rise = m_armed ? (in_bus & ~m_prev & ~mask) : 8'h00;
            m_old  = m_pend;
            m_take = m_busy && ack;
            m_set  = 8'h00;
            if (m_busy) begin
                if (ack) begin
                    m_busy = 0;
                    m_last = m_id;
                end
            end else if (m_old != 0) begin
                m_found = 0;
                for (int k = 1; k <= 8; k++) begin
                    if (!m_found && m_old[(m_last + k) % 8]) begin
                        m_found = 1;
                        m_id    = (m_last + k) % 8;
                        m_time  = m_cap[m_id];
                        m_busy  = 1;
                    end
                end
            end
            if (m_take) m_pend[m_id] = 0;
            for (int i = 0; i < 8; i++) begin
                if (m_rise[i]) begin
                    if (m_old[i] && !(m_take && m_id == i)) m_set[i] = 1;
                    else m_cap[i] = m_ts;
                    m_pend[i] = 1;
                end
            end
            m_ovr  = (clr_ovr ? 8'h00 : m_ovr) | m_set;
            m_ts   = (m_ts + 1) % TS_M;
            m_prev = in_bus;
            m_armed = 1;
        end
    end

    always @(negedge clk) begin
        chk("ev_valid", int'(ev_valid), int'(m_busy));
        if (m_busy) begin
            chk("ev_id", int'(ev_id), m_id);
            chk("ev_time", int'(ev_time), m_time);
        end
        chk("pending", int'(pending), int'(m_pend));
        chk("ovr", int'(ovr), int'(m_ovr));
        chk("ts_now", int'(ts_now), m_ts);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Wait (bounded) for an event, check id and optionally time, then ack it.
    task automatic get_event(input int id, input int t, input string nm);
        for (int n = 0; n < 20 && !ev_valid; n++) step();
        chk({nm, "_valid"}, int'(ev_valid), 1);
        chk({nm, "_id"}, int'(ev_id), id);
        if (t >= 0) chk({nm, "_time"}, int'(ev_time), t);
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    int t0, t1;

    initial begin
        #2;
        chk("rst_valid", int'(ev_valid), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_ts", int'(ts_now), 0);
        step();
        step();
        rst_n = 1'b1;
        ack = 1'b1;                     // ack in IDLE must be ignored
        repeat (4) step();
        ack = 1'b0;
        chk("hi_at_reset_pend", int'(pending), 0);
        chk("hi_at_reset_valid", int'(ev_valid), 0);

        // Line 2 drop and re-rise: event two clocks after the rise is driven.
        in_bus[2] = 1'b0;
        step();
        in_bus[2] = 1'b1;
        t0 = m_ts;
        step();
        chk("l2_pending", int'(pending[2]), 1);
        step();
        chk("l2_valid_2clk", int'(ev_valid), 1);
        get_event(2, t0, "l2");
        in_bus = 8'h00;
        step();

        // Simultaneous 0/3/7 from a fresh reset (last_grant = 7).
        do_reset();
        step();
        in_bus = 8'h89;
        step();
        get_event(0, -1, "rr0");
        get_event(3, -1, "rr3");
        get_event(7, -1, "rr7");
        in_bus = 8'h00;
        step();
        in_bus[3] = 1'b1;
        step();
        get_event(3, -1, "rr3b");
        in_bus = 8'h00;
        step();
        in_bus = 8'h88;
        step();
        get_event(7, -1, "rr7_first");
        get_event(3, -1, "rr3_second");
        in_bus = 8'h00;
        step();

        // Overrun on line 5, first edge keeps its timestamp.
        in_bus[5] = 1'b1;
        t0 = m_ts;
        step();
        in_bus[5] = 1'b0;
        step();
        in_bus[5] = 1'b1;
        step();
        chk("ovr5_set", int'(ovr[5]), 1);
        chk("ovr5_time", int'(ev_time), t0);
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        chk("ovr5_clr", int'(ovr[5]), 0);
        in_bus[5] = 1'b0;
        step();
        in_bus[5] = 1'b1;
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        chk("ovr5_set_wins", int'(ovr[5]), 1);
        get_event(5, t0, "ovr5_ev");
        clr_ovr = 1'b1;
        in_bus = 8'h00;
        step();
        clr_ovr = 1'b0;

        // Mask blocks capture only.
        mask = 8'h02;
        for (int n = 0; n < 6; n++) begin
            in_bus[1] = ~in_bus[1];
            step();
            chk("mask_blk", int'(pending[1]), 0);
        end
        mask = 8'h00;
        in_bus[1] = 1'b1;
        t0 = m_ts;
        step();
        mask = 8'h02;
        get_event(1, t0, "mask_deliver");
        mask = 8'h00;
        in_bus = 8'h00;
        step();

        // Hold without ack, then rise on line 4 in the ack cycle.
        in_bus[4] = 1'b1;
        t0 = m_ts;
        step();
        for (int n = 0; n < 20 && !ev_valid; n++) step();
        in_bus[4] = 1'b0;
        for (int n = 0; n < 10; n++) begin
            step();
            chk("hold_id", int'(ev_id), 4);
            chk("hold_time", int'(ev_time), t0);
        end
        in_bus[4] = 1'b1;
        ack = 1'b1;
        t1 = m_ts;
        step();
        ack = 1'b0;
        chk("ackrise_pend", int'(pending[4]), 1);
        chk("ackrise_ovr", int'(ovr[4]), 0);
        chk("ackrise_drop", int'(ev_valid), 0);
        get_event(4, t1, "ackrise_ev");
        in_bus = 8'h00;
        step();

        // Reset mid-handshake.
        in_bus[6] = 1'b1;
        step();
        for (int n = 0; n < 20 && !ev_valid; n++) step();
        chk("pre_rst_valid", int'(ev_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(ev_valid), 0);
        chk("arst_id", int'(ev_id), 0);
        chk("arst_time", int'(ev_time), 0);
        chk("arst_pending", int'(pending), 0);
        chk("arst_ovr", int'(ovr), 0);
        chk("arst_ts", int'(ts_now), 0);
        step();
        rst_n = 1'b1;
        in_bus = 8'h00;
        step();

        // Timestamp wrap: edges captured at 15 and then 0.
        for (int n = 0; n < 20 && m_ts != TS_M - 1; n++) step();
        in_bus[0] = 1'b1;
        step();
        in_bus[1] = 1'b1;
        step();
        get_event(0, 15, "wrap_f");
        get_event(1, 0, "wrap_0");
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
